// File: rtl/dc_offset_remover.sv
// DC offset remover: estimates the mean of each 2^LOG2_BLOCK-sample block and
// subtracts it from the incoming offset-binary stream, producing signed samples.
module dc_offset_remover #(
    parameter int DATA_WIDTH = 12,
    parameter int LOG2_BLOCK = 10
) (
    input  logic                  clk,
    input  logic                  areset,
    input  logic                  adc_valid,
    input  logic [DATA_WIDTH-1:0] adc_data,
    input  logic                  clear,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  out_valid,
    output logic                  en,
    output logic [DATA_WIDTH-1:0] dc_level
);

    localparam int ACC_W = DATA_WIDTH + LOG2_BLOCK;

    typedef enum logic {
        ACQUIRE,
        TRACK
    } state_t;

    state_t                state_q, state_d;
    logic [ACC_W-1:0]      acc_q, acc_d;
    logic [LOG2_BLOCK-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] dc_level_q, dc_level_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  out_valid_q, out_valid_d;
    logic                  en_q, en_d;

    logic [ACC_W-1:0]      sum;
    logic [DATA_WIDTH:0]   diff;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        dc_level_d  = dc_level_q;
        data_out_d  = data_out_q;
        out_valid_d = 1'b0;
        en_d        = en_q;
        sum         = acc_q + {{LOG2_BLOCK{1'b0}}, adc_data};
        diff        = {1'b0, adc_data} - {1'b0, dc_level_q};

        if (clear) begin
            state_d    = ACQUIRE;
            acc_d      = '0;
            cnt_d      = '0;
            dc_level_d = '0;
            data_out_d = '0;
            en_d       = 1'b0;
        end else if (adc_valid) begin
            if (cnt_q == '1) begin
                dc_level_d = sum[ACC_W-1:LOG2_BLOCK];
                acc_d      = '0;
                cnt_d      = '0;
                if (state_q == ACQUIRE) begin
                    state_d = TRACK;
                    en_d    = 1'b1;
                end
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + {{(LOG2_BLOCK-1){1'b0}}, 1'b1};
            end

            // Correction uses the mean registered before this cycle, so the
            // block-completing sample still sees the old estimate.
            if (state_q == TRACK) begin
                out_valid_d = 1'b1;
                if (diff[DATA_WIDTH] != diff[DATA_WIDTH-1]) begin
                    data_out_d = diff[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                                  : {1'b0, {(DATA_WIDTH-1){1'b1}}};
                end else begin
                    data_out_d = diff[DATA_WIDTH-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q     <= ACQUIRE;
            acc_q       <= '0;
            cnt_q       <= '0;
            dc_level_q  <= '0;
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
            en_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            dc_level_q  <= dc_level_d;
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
            en_q        <= en_d;
        end
    end

    assign data_out  = data_out_q;
    assign out_valid = out_valid_q;
    assign en        = en_q;
    assign dc_level  = dc_level_q;

endmodule

// File: tb/tb_dc_offset_remover.sv
// Self-checking bench for dc_offset_remover: reference model feeds a scoreboard
// queue of expected outputs, plus directed checks of en/dc_level/data_out.
`timescale 1ns/1ps
module tb_dc_offset_remover;

    localparam int DW = 12;
    localparam int LB = 10;
    localparam int BLK = 1 << LB;

    logic          clk = 1'b0;
    logic          areset = 1'b0;
    logic          adc_valid = 1'b0;
    logic [DW-1:0] adc_data = '0;
    logic          clear = 1'b0;
    logic [DW-1:0] data_out;
    logic          out_valid;
    logic          en;
    logic [DW-1:0] dc_level;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    longint        m_acc;
    int            m_cnt;
    int            m_dc;
    bit            m_track;
    logic [DW-1:0] sb[$];

    dc_offset_remover #(.DATA_WIDTH(DW), .LOG2_BLOCK(LB)) dut (
        .clk(clk), .areset(areset), .adc_valid(adc_valid), .adc_data(adc_data),
        .clear(clear), .data_out(data_out), .out_valid(out_valid), .en(en),
        .dc_level(dc_level)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_acc = 0; m_cnt = 0; m_dc = 0; m_track = 0;
        sb.delete();
    endtask

    task automatic model_step(input int d);
        int diff;
        if (m_track) begin
            diff = d - m_dc;
            if (diff > 2047) diff = 2047;
            if (diff < -2048) diff = -2048;
            sb.push_back(DW'(diff));
        end
        m_acc = m_acc + d;
        if (m_cnt == BLK - 1) begin
            m_dc = int'(m_acc / BLK);
            m_acc = 0;
            m_cnt = 0;
            m_track = 1;
        end else begin
            m_cnt = m_cnt + 1;
        end
    endtask

    // Drive one strobe starting at a negedge; returns at the following negedge.
    task automatic send(input int d);
        adc_valid = 1'b1;
        adc_data  = DW'(d);
        model_step(d);
        @(negedge clk);
        adc_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        areset = 1'b1;
        #2;
        model_reset();
        @(negedge clk);
        areset = 1'b0;
    endtask

    // Scoreboard: every out_valid pops one expected value.
    always @(negedge clk) begin
        if (!areset && out_valid) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL sb_unexpected: out_valid=1 data_out=%0d, no output expected", $signed(data_out));
            end else begin
                logic [DW-1:0] exp;
                exp = sb.pop_front();
                if (data_out !== exp) begin
                    miscompares++;
                    $display("FAIL sb_data: got %0d expected %0d", $signed(data_out), $signed(exp));
                end
            end
        end
    end

    task automatic test_reset();
        @(negedge clk);
        areset = 1'b1;
        #1;
        vectors++;
        if ({data_out, out_valid, en, dc_level} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got do=%0h ov=%b en=%b dc=%0h, expected all 0",
                     data_out, out_valid, en, dc_level);
        end
        model_reset();
        @(negedge clk);
        areset = 1'b0;
    endtask

    task automatic test_acquire_const();
        bit en_early;
        do_reset();
        en_early = 0;
        for (int i = 0; i < BLK - 1; i++) begin
            send(2048);
            if (en !== 1'b0) en_early = 1;
        end
        vectors++;
        if (en_early) begin
            miscompares++;
            $display("FAIL acq_en_early: en rose before 1024 samples, expected 0");
        end
        send(2048);
        vectors++;
        if (en !== 1'b1 || dc_level !== 12'd2048) begin
            miscompares++;
            $display("FAIL acq_done: en=%b dc=%0d, expected en=1 dc=2048", en, dc_level);
        end
        send(2048);
        vectors++;
        if (out_valid !== 1'b1 || data_out !== 12'd0) begin
            miscompares++;
            $display("FAIL acq_first_out: ov=%b do=%0d, expected ov=1 do=0", out_valid, $signed(data_out));
        end
        idle(2);
    endtask

    task automatic test_square();
        do_reset();
        for (int i = 0; i < BLK; i++) send((i % 2 == 0) ? 1000 : 3000);
        vectors++;
        if (dc_level !== 12'd2000 || en !== 1'b1) begin
            miscompares++;
            $display("FAIL sq_dc1: dc=%0d en=%b, expected dc=2000 en=1", dc_level, en);
        end
        send(1000);
        vectors++;
        if ($signed(data_out) !== -12'sd1000) begin
            miscompares++;
            $display("FAIL sq_neg: got %0d expected -1000", $signed(data_out));
        end
        send(3000);
        vectors++;
        if ($signed(data_out) !== 12'sd1000) begin
            miscompares++;
            $display("FAIL sq_pos: got %0d expected 1000", $signed(data_out));
        end
        for (int i = 2; i < BLK; i++) send((i % 2 == 0) ? 1000 : 3000);
        vectors++;
        if (dc_level !== 12'd2000 || en !== 1'b1) begin
            miscompares++;
            $display("FAIL sq_dc2: dc=%0d en=%b, expected dc=2000 en=1", dc_level, en);
        end
        idle(2);
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < BLK; i++) send(0);
        send(4095);
        vectors++;
        if (data_out !== 12'd2047) begin
            miscompares++;
            $display("FAIL sat_pos: got %0d expected 2047", $signed(data_out));
        end
        do_reset();
        for (int i = 0; i < BLK; i++) send(4095);
        send(0);
        vectors++;
        if (data_out !== 12'h800) begin
            miscompares++;
            $display("FAIL sat_neg: got %0d expected -2048", $signed(data_out));
        end
        idle(2);
    endtask

    task automatic test_truncation();
        do_reset();
        for (int i = 0; i < BLK - 1; i++) send(0);
        send(1023);
        vectors++;
        if (dc_level !== 12'd0 || en !== 1'b1) begin
            miscompares++;
            $display("FAIL trunc: dc=%0d en=%b, expected dc=0 en=1", dc_level, en);
        end
        idle(2);
    endtask

    task automatic test_block_boundary();
        do_reset();
        for (int i = 0; i < BLK; i++) send(2048);
        for (int i = 0; i < BLK - 1; i++) send(100);
        send(100);
        vectors++;
        if ($signed(data_out) !== -12'sd1948 || dc_level !== 12'd100) begin
            miscompares++;
            $display("FAIL bnd_last: do=%0d dc=%0d, expected do=-1948 dc=100", $signed(data_out), dc_level);
        end
        send(100);
        vectors++;
        if (data_out !== 12'd0) begin
            miscompares++;
            $display("FAIL bnd_next: got %0d expected 0", $signed(data_out));
        end
        idle(2);
    endtask

    task automatic test_clear();
        bit en_early;
        // Still in TRACK from the previous test
        clear = 1'b1;
        adc_valid = 1'b1;
        adc_data = 12'd500;
        @(negedge clk);
        clear = 1'b0;
        adc_valid = 1'b0;
        model_reset();
        vectors++;
        if (en !== 1'b0 || out_valid !== 1'b0 || dc_level !== 12'd0) begin
            miscompares++;
            $display("FAIL clr_state: en=%b ov=%b dc=%0d, expected 0/0/0", en, out_valid, dc_level);
        end
        en_early = 0;
        for (int i = 0; i < BLK - 1; i++) begin
            send(700);
            if (en !== 1'b0) en_early = 1;
        end
        vectors++;
        if (en_early) begin
            miscompares++;
            $display("FAIL clr_en_early: en rose before 1024 strobes after clear");
        end
        send(700);
        vectors++;
        if (en !== 1'b1 || dc_level !== 12'd700) begin
            miscompares++;
            $display("FAIL clr_reacq: en=%b dc=%0d, expected en=1 dc=700", en, dc_level);
        end
        idle(2);
    endtask

    task automatic test_areset_mid();
        bit en_early;
        do_reset();
        for (int i = 0; i < BLK + 300; i++) send(3000);
        #2;
        areset = 1'b1;
        #1;
        vectors++;
        if ({data_out, out_valid, en, dc_level} !== '0) begin
            miscompares++;
            $display("FAIL ares_immediate: do=%0h ov=%b en=%b dc=%0h, expected all 0",
                     data_out, out_valid, en, dc_level);
        end
        model_reset();
        @(negedge clk);
        areset = 1'b0;
        en_early = 0;
        for (int i = 0; i < BLK - 1; i++) begin
            send(1000);
            if (en !== 1'b0) en_early = 1;
        end
        vectors++;
        if (en_early) begin
            miscompares++;
            $display("FAIL ares_en_early: en rose before a full new block");
        end
        send(1000);
        vectors++;
        if (en !== 1'b1 || dc_level !== 12'd1000) begin
            miscompares++;
            $display("FAIL ares_reacq: en=%b dc=%0d, expected en=1 dc=1000", en, dc_level);
        end
        idle(2);
    endtask

    task automatic test_random_gaps();
        do_reset();
        for (int i = 0; i < 2 * BLK + 100; i++) begin
            send($urandom_range(0, 4095));
            idle($urandom_range(0, 5));
        end
        idle(2);
        vectors++;
        if (dc_level !== DW'(m_dc) || en !== 1'b1) begin
            miscompares++;
            $display("FAIL gap_dc: dc=%0d en=%b, expected dc=%0d en=1", dc_level, en, m_dc);
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL gap_missing: %0d expected outputs never appeared, expected 0", sb.size());
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_acquire_const();
        test_square();
        test_saturation();
        test_truncation();
        test_block_boundary();
        test_clear();
        test_areset_mid();
        test_random_gaps();
        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dc_offset_remover.md
Name: dc_offset_remover

Overview:
- Front-end conditioning stage that feeds the autocorrelation period detector.
- Converts raw offset-binary ADC samples to zero-mean signed samples by estimating the DC level over fixed blocks and subtracting it.
- Drives the detector's `data_in` and `en` inputs.
- Block-mean estimation; the first full block is acquisition only, then the block continuously outputs and re-estimates the mean every block.

Parameters:
- DATA_WIDTH, 12, ADC sample width; also the output width.
- LOG2_BLOCK, 10, log2 of samples per mean-estimation block (default 1024 samples).

Ports:
- clk  in  1  system clock (200 MHz).
- areset  in  1  reset, asynchronous, active-high.
- adc_valid  in  1  one-cycle strobe per new ADC sample, already synchronised to clk. May be asserted every cycle or with arbitrary gaps.
- adc_data  in  DATA_WIDTH  unsigned offset-binary sample, valid when adc_valid=1.
- clear  in  1  synchronous restart of estimation.
- data_out  out  DATA_WIDTH  signed DC-removed sample.
- out_valid  out  1  one-cycle pulse marking a new data_out.
- en  out  1  high once a DC estimate exists; output stream valid.
- dc_level  out  DATA_WIDTH  current DC estimate (unsigned).

Behaviour:
- Single clock domain (clk). Reset is asynchronous, active-high (areset).
- Reset values:
  - data_out=0, out_valid=0, en=0, dc_level=0.
  - Accumulator=0, sample counter=0, state=ACQUIRE.
  - All apply immediately on areset assertion, without waiting for a clock edge.
- Internal registers:
  - Accumulator: unsigned, DATA_WIDTH+LOG2_BLOCK bits (22 by default). Cannot overflow.
  - Sample counter: LOG2_BLOCK bits.
- States:
  - ACQUIRE: first block only. No outputs; out_valid stays 0.
  - TRACK: normal operation.
- Accumulation (both states), on adc_valid:
  - acc <= acc + adc_data; cnt <= cnt + 1.
  - When cnt == 2^LOG2_BLOCK-1 (block-completing sample):
    - dc_level <= (acc + adc_data) >> LOG2_BLOCK, truncated (no rounding).
    - acc <= 0; cnt <= 0.
    - If in ACQUIRE: state <= TRACK and en <= 1, both visible the cycle after that sample.
- Output (TRACK only), on adc_valid:
  - diff = adc_data − dc_level, computed as DATA_WIDTH+1-bit signed.
  - diff is saturated to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1], i.e. [−2048, 2047] by default.
  - Result is registered to data_out with out_valid=1 for exactly one cycle. Latency is 1 clk from adc_valid.
  - dc_level used is the value registered before the current cycle. The block-completing sample is corrected with the old mean; the new mean applies from the next sample.
- The sample that moves ACQUIRE→TRACK produces no output.
- data_out holds its last value when out_valid=0.
- en, once high, stays high through later mean updates. It falls only on clear or areset.
- clear (synchronous, one or more cycles):
  - Next state is identical to reset.
  - clear has priority over a simultaneous adc_valid; that sample is dropped and not accumulated.
  - After clear deasserts, a full new block of 2^LOG2_BLOCK samples is needed before en rises.
- areset mid-block discards the partial accumulation.
- adc_data is ignored when adc_valid=0.

Test Plan:
- Reset, then 1024 samples of 2048.
  → en=0 and out_valid=0 throughout. en=1 and dc_level=2048 one cycle after the 1024th strobe.
  → Next sample 2048 gives data_out=0 with out_valid one cycle later.
- Square wave alternating 1000/3000 for 2048 samples.
  → dc_level=2000 after the first block.
  → Second-block outputs alternate −1000/+1000.
  → dc_level still 2000 after the second block; en remains 1.
- Saturation, positive: first block all 0, then sample 4095.
  → data_out=2047 (not 4095).
- Saturation, negative: separate run, first block all 4095, then sample 0.
  → data_out=−2048.
- Truncation: first block of 1023 zeros plus one sample of 1023.
  → dc_level=0.
- Block boundary: second block of constant 100 following a first block of 2048.
  → The sample completing block 2 outputs 100−2048=−1948.
  → The following sample outputs 0 (new dc_level=100).
- clear asserted in TRACK in the same cycle as adc_valid.
  → en=0 next cycle; that sample produces no out_valid.
  → en stays low until exactly 1024 further strobes.
- areset asserted mid-block between clock edges.
  → All outputs are 0 immediately.
  → After release, the next block restarts from count 0.
- Irregular adc_valid spacing (random 0–5 idle cycles).
  → Results are identical to back-to-back strobes.
